yin_diff_engine: RTL and testbench
==================================

YIN_DIFF_ENGINE -- requirements
Module: yin_diff_engine

Interface
REQ-001 Parameters SHALL be: WIDTH 16, unsigned sample width; WINDOW_SIZE 2048, buffered samples, power of 2; TAUMAX 1024, lags computed, power of 2, < WINDOW_SIZE; LANES 4, parallel lags, power of 2, divides TAUMAX; HOP 512, new samples per frame after the first, 1..WINDOW_SIZE.
REQ-002 Derived constants: N = WINDOW_SIZE-TAUMAX (integration length); ACC_WIDTH = 2*WIDTH+$clog2(N).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
sample_in  in  WIDTH  audio sample
valid_in  in  1  sample_in valid
ready_out  out  1  sample accepted when valid_in&&ready_out
diff_out  out  ACC_WIDTH  d(tau)
tau_out  out  $clog2(TAUMAX)  lag of diff_out
diff_valid_out  out  1  diff_out/tau_out valid
diff_ready_in  in  1  consumer accepts beat
diff_last_out  out  1  beat carries tau=TAUMAX-1
busy_out  out  1  high in COMPUTE or DRAIN

Function
REQ-005 Per frame the block SHALL output d(tau) = sum over j=0..N-1 of |x[j]-x[j+tau]|^2 for tau = 0..TAUMAX-1, x[0] the oldest sample in the window; d(0)=0.
REQ-006 Arithmetic SHALL be unsigned: |a-b| in WIDTH bits, square 2*WIDTH bits, accumulation ACC_WIDTH bits, no overflow or saturation possible.
REQ-007 Samples SHALL be stored in a circular buffer of WINDOW_SIZE entries with a base pointer; addresses wrap modulo WINDOW_SIZE.
REQ-008 FSM states: FILL, COMPUTE, DRAIN.
REQ-009 FILL: ready_out=1; each accepted sample is written at the write pointer, which then increments. After the first reset, COMPUTE is entered after WINDOW_SIZE accepts; for later frames, after HOP accepts.
REQ-010 On each FILL->COMPUTE transition, base = write pointer (oldest sample), group g = 0.
REQ-011 COMPUTE: LANES lags tau = g*LANES+l are processed concurrently. One j per cycle, j = 0..N-1. Pipeline: read 1 cycle, subtract 1, square 1, accumulate 1. DRAIN is entered exactly N+4 cycles after COMPUTE entry; accumulators are cleared on entry.
REQ-012 DRAIN: emits LANES beats with ascending tau using a valid/ready handshake. diff_out, tau_out and diff_last_out SHALL hold stable while diff_valid_out=1 and diff_ready_in=0.
REQ-013 After the last DRAIN beat: if g < TAUMAX/LANES-1, increment g and return to COMPUTE; else go to FILL.
REQ-014 ready_out SHALL be 0 in COMPUTE and DRAIN; valid_in is ignored there (backpressure, no sample loss).
REQ-015 diff_valid_out SHALL be 0 outside DRAIN; diff_last_out only with tau_out=TAUMAX-1.
REQ-016 busy_out SHALL be 1 iff state is COMPUTE or DRAIN.
REQ-017 HOP=WINDOW_SIZE SHALL yield non-overlapping frames; a wrap of the write pointer at the last address SHALL NOT stall FILL.

Reset
REQ-018 rst_in SHALL force FILL, clear write pointer, base, group, accumulators and the fill counter, and set the "first frame" flag.
REQ-019 During and after reset: ready_out=1 (from the first cycle after reset); diff_valid_out, diff_last_out, busy_out, diff_out, tau_out = 0.
REQ-020 Reset mid-COMPUTE or mid-DRAIN SHALL abandon the frame with no further beats; the next frame needs WINDOW_SIZE samples.
REQ-021 Buffer contents need not be cleared.

Structure
REQ-022 A shared package yin_pkg SHALL hold the state enum and the ACC_WIDTH/N derivation functions.
REQ-023 One sub-module, yin_lane (subtract-square-accumulate pipeline for one lag), SHALL be instantiated LANES times.
REQ-024 Each lane SHALL own a buffer read port, implemented as replicated dual-port BRAM.

Verification (WIDTH=8, WINDOW_SIZE=16, TAUMAX=8, LANES=2, HOP=4, N=8)
REQ-025 Constant 37 x16 -> 8 beats, all diff_out=0, tau 0..7, diff_last_out on tau=7.
REQ-026 Ramp x=0..15 -> d(tau)=8*tau^2; tau=3 gives 72, tau=7 gives 392.
REQ-027 Square wave 0,0,10,10 repeated -> d(4)=0, d(2)=800, d(1)=400.
REQ-028 Ramp frame, then samples 16..19 -> exactly 4 accepts, then a second frame identical to REQ-026 (tests wrap and base).
REQ-029 diff_ready_in held low 5 cycles on the tau=2 beat -> outputs stable, no beat lost or duplicated, ready_out=0 throughout.
REQ-030 rst_in pulse during group 2 COMPUTE -> no diff_valid_out; ramp needs 16 new samples before beats resume.

Source files
------------

// File: rtl/yin_pkg.sv
// Shared state encoding and size derivations for the YIN difference engine.
package yin_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } yin_state_e;

  // Integration length: how many j terms each d(tau) sums.
  function automatic int calcN(input int windowSize, input int tauMax);
    return windowSize - tauMax;
  endfunction

  // Wide enough that N squared WIDTH-bit differences can never overflow.
  function automatic int calcAccWidth(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/yin_lane.sv
// One lag of the difference function: private buffer replica, then
// read -> subtract -> square -> accumulate, one stage per cycle.
module yin_lane
  import yin_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2048,
  parameter int AW        = $clog2(DEPTH),
  parameter int ACC_WIDTH = calcAccWidth(16, calcN(2048, 1024))
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wrEn_i,
  input  logic [AW-1:0]        wrAddr_i,
  input  logic [WIDTH-1:0]     wrData_i,
  input  logic [AW-1:0]        rdAddr_i,
  input  logic                 rdValid_i,
  input  logic [WIDTH-1:0]     refData_i,
  input  logic                 clr_i,
  output logic [ACC_WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     lagData_q;
  logic                 rdValid_q, diffValid_q, sqValid_q;
  logic [WIDTH-1:0]     diff_d, diff_q;
  logic [2*WIDTH-1:0]   sq_q;
  logic [ACC_WIDTH-1:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (wrEn_i) mem[wrAddr_i] <= wrData_i;
    lagData_q <= mem[rdAddr_i];
  end

  // refData_i is registered upstream, so it lines up with lagData_q.
  always_comb begin
    diff_d = (refData_i >= lagData_q) ? (refData_i - lagData_q) : (lagData_q - refData_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdValid_q   <= 1'b0;
      diffValid_q <= 1'b0;
      sqValid_q   <= 1'b0;
      diff_q      <= '0;
      sq_q        <= '0;
      acc_q       <= '0;
    end else begin
      rdValid_q   <= rdValid_i;
      diffValid_q <= rdValid_q;
      sqValid_q   <= diffValid_q;
      diff_q      <= diff_d;
      sq_q        <= {{WIDTH{1'b0}}, diff_q} * {{WIDTH{1'b0}}, diff_q};
      if (clr_i)          acc_q <= '0;
      else if (sqValid_q) acc_q <= acc_q + ACC_WIDTH'(sq_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/yin_diff_engine.sv
// YIN difference function engine: buffers a sliding window of samples and
// streams d(tau) for tau = 0..TAUMAX-1, LANES lags per compute pass.
module yin_diff_engine
  import yin_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = 2048,
  parameter int TAUMAX      = 1024,
  parameter int LANES       = 4,
  parameter int HOP         = 512
) (
  input  logic                                                     clk_in,
  input  logic                                                     rst_in,
  input  logic [WIDTH-1:0]                                         sample_in,
  input  logic                                                     valid_in,
  output logic                                                     ready_out,
  output logic [calcAccWidth(WIDTH, calcN(WINDOW_SIZE, TAUMAX))-1:0] diff_out,
  output logic [$clog2(TAUMAX)-1:0]                                tau_out,
  output logic                                                     diff_valid_out,
  input  logic                                                     diff_ready_in,
  output logic                                                     diff_last_out,
  output logic                                                     busy_out
);

  localparam int N         = calcN(WINDOW_SIZE, TAUMAX);
  localparam int ACC_WIDTH = calcAccWidth(WIDTH, N);
  localparam int AW        = $clog2(WINDOW_SIZE);
  localparam int TW        = $clog2(TAUMAX);
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW        = $clog2(N + 4);
  localparam int FW        = AW + 1;
  localparam int GROUPS    = TAUMAX / LANES;

  yin_state_e           state_q, state_d;
  logic [AW-1:0]        wrPtr_q, wrPtr_d, base_q, base_d;
  logic [TW-1:0]        group_q, group_d;
  logic [FW-1:0]        fillCnt_q, fillCnt_d;
  logic                 first_q, first_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [LW-1:0]        beat_q, beat_d;
  logic                 accept, clrAcc, issue, beatDone;
  logic [FW-1:0]        fillTarget;
  logic [TW-1:0]        tauBase;
  logic [AW-1:0]        refAddr;
  logic [WIDTH-1:0]     refMem [WINDOW_SIZE];
  logic [WIDTH-1:0]     refData_q;
  logic [ACC_WIDTH-1:0] laneAcc [LANES];

  // Outputs are masked while reset is held so nothing leaks from an abandoned frame.
  assign ready_out      = (state_q == ST_FILL);
  assign accept         = valid_in && ready_out && !rst_in;
  assign busy_out       = ((state_q == ST_COMPUTE) || (state_q == ST_DRAIN)) && !rst_in;
  assign diff_valid_out = (state_q == ST_DRAIN) && !rst_in;
  assign beatDone       = diff_valid_out && diff_ready_in;
  assign tauBase        = TW'(group_q * LANES);
  assign tau_out        = diff_valid_out ? (tauBase + TW'(beat_q)) : '0;
  assign diff_out       = diff_valid_out ? laneAcc[beat_q] : '0;
  assign diff_last_out  = diff_valid_out && (group_q == TW'(GROUPS - 1)) && (beat_q == LW'(LANES - 1));
  assign issue          = (state_q == ST_COMPUTE) && (cyc_q < CW'(N));
  assign refAddr        = base_q + AW'(cyc_q);
  assign fillTarget     = first_q ? FW'(WINDOW_SIZE) : FW'(HOP);

  always_ff @(posedge clk_in) begin
    if (accept) refMem[wrPtr_q] <= sample_in;
    refData_q <= refMem[refAddr];
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    yin_lane #(
      .WIDTH(WIDTH), .DEPTH(WINDOW_SIZE), .AW(AW), .ACC_WIDTH(ACC_WIDTH)
    ) uLane (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .wrEn_i   (accept),
      .wrAddr_i (wrPtr_q),
      .wrData_i (sample_in),
      .rdAddr_i (refAddr + AW'(tauBase) + AW'(l)),
      .rdValid_i(issue),
      .refData_i(refData_q),
      .clr_i    (clrAcc),
      .acc_o    (laneAcc[l])
    );
  end

  // COMPUTE lasts N issue cycles plus the pipeline depth before DRAIN.
  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    base_d    = base_q;
    group_d   = group_q;
    fillCnt_d = fillCnt_q;
    first_d   = first_q;
    cyc_d     = cyc_q;
    beat_d    = beat_q;
    clrAcc    = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          wrPtr_d = wrPtr_q + 1'b1;
          if (fillCnt_q == fillTarget - 1'b1) begin
            state_d   = ST_COMPUTE;
            base_d    = wrPtr_q + 1'b1;
            group_d   = '0;
            cyc_d     = '0;
            fillCnt_d = '0;
            first_d   = 1'b0;
            clrAcc    = 1'b1;
          end else begin
            fillCnt_d = fillCnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (cyc_q == CW'(N + 3)) begin
          state_d = ST_DRAIN;
          beat_d  = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (beatDone) begin
          if (beat_q == LW'(LANES - 1)) begin
            if (group_q == TW'(GROUPS - 1)) begin
              state_d = ST_FILL;
            end else begin
              state_d = ST_COMPUTE;
              group_d = group_q + 1'b1;
              cyc_d   = '0;
              clrAcc  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_FILL;
      wrPtr_q   <= '0;
      base_q    <= '0;
      group_q   <= '0;
      fillCnt_q <= '0;
      first_q   <= 1'b1;
      cyc_q     <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      base_q    <= base_d;
      group_q   <= group_d;
      fillCnt_q <= fillCnt_d;
      first_q   <= first_d;
      cyc_q     <= cyc_d;
      beat_q    <= beat_d;
    end
  end

endmodule

// File: tb/tb_yin_diff_engine.sv
// Self-checking bench for yin_diff_engine: directed patterns plus random
// frames, compared against a plain-arithmetic model of d(tau).
module tb_yin_diff_engine;

  localparam int WIDTH = 8;
  localparam int WIN   = 16;
  localparam int TAUMAX = 8;
  localparam int LANES = 2;
  localparam int HOP   = 4;
  localparam int NINT  = WIN - TAUMAX;
  localparam int ACCW  = 2 * WIDTH + $clog2(NINT);

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic [ACCW-1:0]  diff_out;
  logic [2:0]       tau_out;
  logic             diff_valid_out;
  logic             diff_ready_in = 1'b0;
  logic             diff_last_out;
  logic             busy_out;

  int total = 0;
  int bad = 0;
  int hist[$];
  int lastGot[TAUMAX];

  yin_diff_engine #(
    .WIDTH(WIDTH), .WINDOW_SIZE(WIN), .TAUMAX(TAUMAX), .LANES(LANES), .HOP(HOP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .valid_in(valid_in),
    .ready_out(ready_out), .diff_out(diff_out), .tau_out(tau_out),
    .diff_valid_out(diff_valid_out), .diff_ready_in(diff_ready_in),
    .diff_last_out(diff_last_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Hold reset two cycles, checking the idle outputs while it is asserted.
  task automatic resetDut(input string tag);
    valid_in = 1'b0;
    diff_ready_in = 1'b0;
    rst_in = 1'b1;
    tick();
    tick();
    checkOutput({tag, "_rstValid"}, diff_valid_out, 0);
    checkOutput({tag, "_rstBusy"}, busy_out, 0);
    checkOutput({tag, "_rstLast"}, diff_last_out, 0);
    checkOutput({tag, "_rstDiff"}, diff_out, 0);
    checkOutput({tag, "_rstTau"}, tau_out, 0);
    rst_in = 1'b0;
    hist.delete();
    checkOutput({tag, "_rstReady"}, ready_out, 1);
  endtask

  // The bench only feeds samples while the block should be filling, so ready must already be high.
  task automatic applyStimulus(input int s, input bit randomGap);
    int gap;
    gap = randomGap ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < gap; i++) tick();
    sample_in = WIDTH'(s);
    valid_in = 1'b1;
    checkOutput($sformatf("readyFill_s%0d", s), ready_out, 1);
    tick();
    valid_in = 1'b0;
    hist.push_back(s);
  endtask

  // Model d(tau) from the newest WIN samples, then drain the block's beats with backpressure.
  task automatic collectFrame(input string tag, input int beats, input int stallTau, input int stallLen);
    int exp[TAUMAX];
    int waitCnt;
    int hold;
    int base;
    base = hist.size() - WIN;
    for (int tau = 0; tau < TAUMAX; tau++) begin
      exp[tau] = 0;
      for (int j = 0; j < NINT; j++)
        exp[tau] += (hist[base + j] - hist[base + j + tau]) * (hist[base + j] - hist[base + j + tau]);
    end
    for (int k = 0; k < beats; k++) begin
      diff_ready_in = 1'b0;
      waitCnt = 0;
      while (!diff_valid_out && waitCnt < 100) begin
        valid_in = 1'b1;
        sample_in = WIDTH'($urandom_range(0, 255));
        tick();
        waitCnt++;
      end
      if (!diff_valid_out) begin
        checkOutput($sformatf("%s_beatTimeout%0d", tag, k), 0, 1);
        valid_in = 1'b0;
        return;
      end
      checkOutput($sformatf("%s_tau%0d", tag, k), tau_out, k);
      checkOutput($sformatf("%s_diff%0d", tag, k), diff_out, exp[k]);
      checkOutput($sformatf("%s_last%0d", tag, k), diff_last_out, (k == TAUMAX - 1) ? 1 : 0);
      checkOutput($sformatf("%s_busy%0d", tag, k), busy_out, 1);
      checkOutput($sformatf("%s_ready%0d", tag, k), ready_out, 0);
      lastGot[k] = int'(diff_out);
      hold = (k == stallTau) ? stallLen : int'($urandom_range(0, 1));
      for (int h = 0; h < hold; h++) begin
        tick();
        checkOutput($sformatf("%s_holdValid%0d", tag, k), diff_valid_out, 1);
        checkOutput($sformatf("%s_holdTau%0d", tag, k), tau_out, k);
        checkOutput($sformatf("%s_holdDiff%0d", tag, k), diff_out, exp[k]);
        checkOutput($sformatf("%s_holdReady%0d", tag, k), ready_out, 0);
      end
      diff_ready_in = 1'b1;
      tick();
      diff_ready_in = 1'b0;
    end
    valid_in = 1'b0;
    if (beats == TAUMAX) begin
      checkOutput({tag, "_endValid"}, diff_valid_out, 0);
      checkOutput({tag, "_endReady"}, ready_out, 1);
      checkOutput({tag, "_endBusy"}, busy_out, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut("init");

    // Constant input: every lag differs by zero.
    for (int i = 0; i < WIN; i++) applyStimulus(37, 1'b0);
    collectFrame("const", TAUMAX, -1, 0);
    checkOutput("const_d5", lastGot[5], 0);

    // Ramp with a long stall on the tau=2 beat.
    resetDut("rampRst");
    for (int i = 0; i < WIN; i++) applyStimulus(i, 1'b1);
    collectFrame("ramp", TAUMAX, 2, 5);
    checkOutput("ramp_d3", lastGot[3], 72);
    checkOutput("ramp_d7", lastGot[7], 392);

    // One hop later the window is 4..19, which wraps the buffer but keeps the same d(tau).
    for (int i = 16; i < 20; i++) applyStimulus(i, 1'b1);
    checkOutput("hop_readyAfter4", ready_out, 0);
    collectFrame("hop", TAUMAX, -1, 0);
    checkOutput("hop_d3", lastGot[3], 72);
    checkOutput("hop_d7", lastGot[7], 392);

    // Square wave 0,0,10,10.
    resetDut("sqRst");
    for (int i = 0; i < WIN; i++) applyStimulus(((i % 4) < 2) ? 0 : 10, 1'b0);
    collectFrame("square", TAUMAX, -1, 0);
    checkOutput("square_d1", lastGot[1], 400);
    checkOutput("square_d2", lastGot[2], 800);
    checkOutput("square_d4", lastGot[4], 0);

    // Random first frame followed by several overlapping hops.
    resetDut("rndRst");
    for (int i = 0; i < WIN; i++) applyStimulus(int'($urandom_range(0, 255)), 1'b1);
    collectFrame("rnd0", TAUMAX, int'($urandom_range(0, TAUMAX - 1)), 3);
    for (int f = 1; f <= 5; f++) begin
      for (int i = 0; i < HOP; i++) applyStimulus(int'($urandom_range(0, 255)), 1'b1);
      collectFrame($sformatf("rnd%0d", f), TAUMAX, int'($urandom_range(0, TAUMAX - 1)), 2);
    end

    // Reset while group 2 is computing: the frame is dropped and a full window is needed again.
    resetDut("abRst");
    for (int i = 0; i < WIN; i++) applyStimulus(i, 1'b0);
    collectFrame("abort", 2 * LANES, -1, 0);
    tick();
    tick();
    checkOutput("abort_busyG2", busy_out, 1);
    rst_in = 1'b1;
    tick();
    checkOutput("abort_rstValid", diff_valid_out, 0);
    checkOutput("abort_rstBusy", busy_out, 0);
    rst_in = 1'b0;
    hist.delete();
    for (int i = 0; i < WIN - 1; i++) begin
      applyStimulus(i, 1'b0);
      checkOutput($sformatf("abort_noBeat%0d", i), diff_valid_out, 0);
    end
    checkOutput("abort_idleAfter15", busy_out, 0);
    applyStimulus(WIN - 1, 1'b0);
    collectFrame("afterAbort", TAUMAX, -1, 0);
    checkOutput("afterAbort_d3", lastGot[3], 72);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
